// File: rtl/md_sequencer_if.sv
// Bundles the HI/LO unit's E-stage request, status and result signals.
// The master drives the request; the sequencer sits on the slave modport.
interface md_sequencer_if;
    logic        start;
    logic [3:0]  hilo_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    modport master (
        output start, hilo_op, rs_val, rt_val,
        input  busy, hi, lo, mf_data
    );

    modport slave (
        input  start, hilo_op, rs_val, rt_val,
        output busy, hi, lo, mf_data
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue and held in temp_hi/temp_lo until the busy window ends.
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    md_sequencer_if.slave md_if
);

    // state | meaning
    // IDLE  | accepts mult/div/mthi/mtlo; HI/LO stable
    // BUSY  | operation in flight; counter runs down to the commit edge
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] temp_hi_q, temp_hi_d;
    logic [31:0] temp_lo_q, temp_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic [31:0] rs, rt;
    logic        sgn_mul, sgn_div;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, uq, ur, quot, rem;

    assign rs      = md_if.rs_val;
    assign rt      = md_if.rt_val;
    assign sgn_mul = (md_if.hilo_op == OP_MULT);
    assign sgn_div = (md_if.hilo_op == OP_DIV);

    // One 64-bit multiplier; signedness only changes the operand extension.
    assign prod = {{32{sgn_mul & rs[31]}}, rs} * {{32{sgn_mul & rt[31]}}, rt};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign a_mag = (sgn_div && rs[31]) ? (~rs + 32'd1) : rs;
    assign b_mag = (sgn_div && rt[31]) ? (~rt + 32'd1) : rt;
    assign uq    = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign ur    = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign quot  = (sgn_div && (rs[31] ^ rt[31])) ? (~uq + 32'd1) : uq;
    assign rem   = (sgn_div && rs[31]) ? (~ur + 32'd1) : ur;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (md_if.start) begin
                    case (md_if.hilo_op)
                        OP_MULT, OP_MULTU: begin
                            temp_hi_d = prod[63:32];
                            temp_lo_d = prod[31:0];
                            dz_d      = 1'b0;
                            cnt_d     = MULT_LD;
                            state_d   = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            temp_hi_d = rem;
                            temp_lo_d = quot;
                            dz_d      = (rt == 32'd0);
                            cnt_d     = DIV_LD;
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // A divide by zero still burns its cycles but leaves HI/LO alone.
                    if (!dz_q) begin
                        hi_d = temp_hi_q;
                        lo_d = temp_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md_if.mf_data = 32'd0;
        if (md_if.hilo_op == OP_MFHI)      md_if.mf_data = hi_q;
        else if (md_if.hilo_op == OP_MFLO) md_if.mf_data = lo_q;
    end

    assign md_if.busy = (state_q == BUSY);
    assign md_if.hi   = hi_q;
    assign md_if.lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: busy window length, arithmetic results,
// mthi/mtlo/mf paths, dropped starts while busy, and reset mid-operation.
module tb_md_sequencer;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    md_sequencer_if bus ();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .md_if   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one start pulse, then counts busy cycles (bounded at 40).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.hilo_op = op;
        bus.rs_val  = a;
        bus.rt_val  = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_op = 4'd0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.hilo_op = 4'd5;
        bus.rs_val  = 32'h0;
        bus.rt_val  = 32'h0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        n_vec++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_vec++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        n_vec++; if (bus.mf_data !== 32'h0) begin n_err++; $display("FAIL reset_mf got %h want 0", bus.mf_data); end
        rst_n = 1'b1;
        bus.hilo_op = 4'd0;
    endtask

    task automatic test_mult();
        int n;
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
        n_vec++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        n_vec++; if (bus.lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo got %h want fffffffa", bus.lo); end
        run_op(4'd1, 32'h0001_0000, 32'h0001_0000, n);
        n_vec++; if (bus.hi !== 32'h1 || bus.lo !== 32'h0) begin n_err++; $display("FAIL mult_pos got %h_%h want 00000001_00000000", bus.hi, bus.lo); end
    endtask

    task automatic test_multu();
        int n;
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        n_vec++; if (n !== 5) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
        n_vec++; if (bus.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
        n_vec++; if (bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        n_vec++; if (n !== 10) begin n_err++; $display("FAIL div_busy_cycles got %0d want 10", n); end
        n_vec++; if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
        n_vec++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, n);
        n_vec++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'h1) begin n_err++; $display("FAIL div_negdivisor got %h/%h want 00000001/fffffffd", bus.hi, bus.lo); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        n_vec++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin n_err++; $display("FAIL div_overflow got %h/%h want 00000000/80000000", bus.hi, bus.lo); end
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, n);
        n_vec++; if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'h1) begin n_err++; $display("FAIL divu got %h/%h want 00000001/7ffffffc", bus.hi, bus.lo); end
    endtask

    task automatic test_divu_zero();
        int n;
        run_op(4'd7, 32'h11, 32'h0, n);
        run_op(4'd8, 32'h22, 32'h0, n);
        run_op(4'd4, 32'd7, 32'd0, n);
        n_vec++; if (n !== 10) begin n_err++; $display("FAIL divzero_busy_cycles got %0d want 10", n); end
        n_vec++; if (bus.hi !== 32'h11) begin n_err++; $display("FAIL divzero_hi got %h want 00000011", bus.hi); end
        n_vec++; if (bus.lo !== 32'h22) begin n_err++; $display("FAIL divzero_lo got %h want 00000022", bus.lo); end
    endtask

    task automatic test_mt_mf();
        int n;
        run_op(4'd7, 32'hABCD_1234, 32'h0, n);
        n_vec++; if (n !== 0) begin n_err++; $display("FAIL mthi_busy got %0d want 0", n); end
        n_vec++; if (bus.hi !== 32'hABCD_1234) begin n_err++; $display("FAIL mthi_hi got %h want abcd1234", bus.hi); end
        n_vec++; if (bus.lo !== 32'h22) begin n_err++; $display("FAIL mthi_lo_kept got %h want 00000022", bus.lo); end
        bus.hilo_op = 4'd5; #1;
        n_vec++; if (bus.mf_data !== 32'hABCD_1234) begin n_err++; $display("FAIL mfhi got %h want abcd1234", bus.mf_data); end
        bus.hilo_op = 4'd6; #1;
        n_vec++; if (bus.mf_data !== 32'h22) begin n_err++; $display("FAIL mflo got %h want 00000022", bus.mf_data); end
        bus.hilo_op = 4'd9; #1;
        n_vec++; if (bus.mf_data !== 32'h0) begin n_err++; $display("FAIL mf_other got %h want 0", bus.mf_data); end
        bus.hilo_op = 4'd0;
    endtask

    task automatic test_no_effect();
        int n;
        @(negedge clk);
        bus.start = 1'b0; bus.hilo_op = 4'd7; bus.rs_val = 32'h5555_5555;
        @(negedge clk);
        bus.hilo_op = 4'd1;
        @(negedge clk);
        n_vec++; if (bus.hi !== 32'hABCD_1234 || bus.busy !== 1'b0) begin n_err++; $display("FAIL start0 got hi=%h busy=%b want abcd1234/0", bus.hi, bus.busy); end
        run_op(4'd12, 32'h5555_5555, 32'h3, n);
        n_vec++; if (n !== 0 || bus.hi !== 32'hABCD_1234 || bus.lo !== 32'h22) begin n_err++; $display("FAIL undef_op got n=%0d hi=%h lo=%h want 0/abcd1234/00000022", n, bus.hi, bus.lo); end
    endtask

    task automatic test_busy_drop();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.hilo_op = 4'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.hilo_op = 4'd0;
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            if (n == 2 || n == 9) begin
                bus.start = 1'b1; bus.hilo_op = (n == 2) ? 4'd7 : 4'd1; bus.rs_val = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0; bus.hilo_op = 4'd0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.hilo_op = 4'd0;
        n_vec++; if (n !== 10) begin n_err++; $display("FAIL drop_busy_cycles got %0d want 10", n); end
        n_vec++; if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin n_err++; $display("FAIL drop_result got %h/%h want 00000002/0000000e", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.hilo_op = 4'd1; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.hilo_op = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
        rst_n = 1'b0; #1;
        n_vec++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_err++; $display("FAIL mid_reset got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy) n++;
        end
        n_vec++; if (n !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_err++; $display("FAIL mid_no_commit got busy_cycles=%0d hi=%h lo=%h want 0/0/0", n, bus.hi, bus.lo); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_mt_mf();
        test_no_effect();
        test_busy_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
